mem_port_arbiter: RTL

//  Shares one slow memory port (28-bit line address, 128-bit line data, mem_ready handshake) between I_cache and D_cache.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 32 +++
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the cache-to-memory port arbiter: FSM states, op encoding, width defaults.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 28;
  localparam int unsigned DATA_W_DEF = 128;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StGrant   = 2'd1,
    StRelease = 2'd2
  } arb_state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } arb_op_e;

  // A request with both read and write raised is treated as a write.
  function automatic arb_op_e op_of(input logic wr);
    return wr ? OP_WR : OP_RD;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way picker between I (side 0) and D (side 1), round-robin or D-wins-ties.
module rr_arb2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_icache_i,
  input  logic req_dcache_i,
  input  logic update_i,
  output logic pick_d_o
);

  logic last_d_q;

  always_comb begin
    if (req_icache_i && req_dcache_i) begin
      pick_d_o = FIXED_PRIO ? 1'b1 : ~last_d_q;
    end else begin
      pick_d_o = req_dcache_i;
    end
  end

  // Pointer resets to D so that I wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_d_q <= 1'b1;
    end else if (update_i) begin
      last_d_q <= pick_d_o;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one line-wide memory port between I_cache and D_cache, with a per-grant watchdog.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter bit          FIXED_PRIO = 1'b0,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              grant_d,
  output logic              err
);

  localparam int unsigned      CntW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0]  TimeoutVal = CntW'(TIMEOUT);

  arb_state_e        state_q, state_d;
  arb_op_e           op_q, op_d;
  logic              grant_d_q, grant_d_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;
  logic              err_q, err_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic i_pend, d_pend, pick_d, arb_update, win_wr;

  assign i_pend = i_read | i_write;
  assign d_pend = d_read | d_write;

  rr_arb2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_icache_i (i_pend),
    .req_dcache_i (d_pend),
    .update_i     (arb_update),
    .pick_d_o     (pick_d)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    grant_d_d   = grant_d_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    err_d       = err_q;
    cnt_d       = cnt_q;
    arb_update  = 1'b0;
    win_wr      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_pend || d_pend) begin
          arb_update  = 1'b1;
          win_wr      = pick_d ? d_write : i_write;
          grant_d_d   = pick_d;
          op_d        = op_of(win_wr);
          mem_read_d  = ~win_wr;
          mem_write_d = win_wr;
          mem_addr_d  = pick_d ? d_addr : i_addr;
          mem_wdata_d = pick_d ? d_wdata : i_wdata;
          cnt_d       = '0;
          state_d     = StGrant;
        end
      end
      StGrant: begin
        if (mem_ready) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (grant_d_q) begin
            d_ready_d = 1'b1;
            if (op_q == OP_RD) d_rdata_d = mem_rdata;
          end else begin
            i_ready_d = 1'b1;
            if (op_q == OP_RD) i_rdata_d = mem_rdata;
          end
          state_d = StRelease;
        end else if (TIMEOUT != 0) begin
          // Saturating count; err stays set until reset, the grant keeps waiting.
          if (cnt_q != TimeoutVal) cnt_d = cnt_q + CntW'(1);
          if (cnt_d == TimeoutVal) err_d = 1'b1;
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= OP_RD;
      grant_d_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      grant_d_q   <= grant_d_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign grant_d   = grant_d_q;
  assign err       = err_q;

endmodule
